// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the 16-bit core
module multicycle_controller #(
  parameter int MEM_WAIT_MAX = 8,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       opcode,
  input  logic [3:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             i_or_d,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             reg_dest,
  output logic             alu_src,
  output logic             ext_op,
  output logic [2:0]       alu_ctr,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic [2:0]       state,
  output logic             illegal_op,
  output logic             bus_err,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd7
  } state_t;

  localparam logic [3:0] OP_R    = 4'd0;
  localparam logic [3:0] OP_ANDI = 4'd1;
  localparam logic [3:0] OP_ORI  = 4'd2;
  localparam logic [3:0] OP_BNQ  = 4'd3;
  localparam logic [3:0] OP_LW   = 4'd4;
  localparam logic [3:0] OP_SW   = 4'd5;

  // Timeout fires on the MEM_WAIT_MAX-th consecutive unanswered request cycle.
  localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_MAX - 1);

  state_t     cur;
  logic [7:0] wait_cnt;
  logic       mem_phase;
  logic       alu_phase;
  logic       timeout;
  logic       retire;
  logic       unused_funct;

  assign mem_phase    = (cur == S_FETCH) || (cur == S_MEM);
  assign alu_phase    = (cur == S_EXEC) || (cur == S_MEM) || (cur == S_WB);
  assign timeout      = mem_phase && !mem_ready && (wait_cnt == WAIT_LAST);
  assign retire       = ((cur == S_EXEC) && (opcode == OP_BNQ)) ||
                        ((cur == S_MEM) && mem_ready && (opcode == OP_SW)) ||
                        (cur == S_WB);
  assign state        = cur;
  assign unused_funct = funct[3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur        <= S_IDLE;
      wait_cnt   <= 8'd0;
      instr_cnt  <= '0;
      illegal_op <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      case (cur)
        S_IDLE: cur <= S_FETCH;
        S_FETCH: begin
          if (mem_ready) begin
            cur <= S_DECODE;
          end else if (timeout) begin
            bus_err <= 1'b1;
            cur     <= S_HALT;
          end
        end
        S_DECODE: begin
          if (opcode <= OP_SW) begin
            cur <= S_EXEC;
          end else begin
            illegal_op <= 1'b1;
            cur        <= S_HALT;
          end
        end
        S_EXEC: begin
          case (opcode)
            OP_R, OP_ANDI, OP_ORI: cur <= S_WB;
            OP_LW, OP_SW:          cur <= S_MEM;
            OP_BNQ:                cur <= S_FETCH;
            default: begin
              illegal_op <= 1'b1;
              cur        <= S_HALT;
            end
          endcase
        end
        S_MEM: begin
          if (mem_ready) begin
            cur <= (opcode == OP_SW) ? S_FETCH : S_WB;
          end else if (timeout) begin
            bus_err <= 1'b1;
            cur     <= S_HALT;
          end
        end
        S_WB:    cur <= S_FETCH;
        default: cur <= S_HALT;
      endcase

      if (retire) begin
        instr_cnt <= instr_cnt + CNT_W'(1);
      end

      // Any accepted request, timeout or leaving the memory states restarts the count.
      if (mem_phase && !mem_ready && !timeout) begin
        wait_cnt <= wait_cnt + 8'd1;
      end else begin
        wait_cnt <= 8'd0;
      end
    end
  end

  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    i_or_d     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    reg_dest   = 1'b0;
    alu_src    = 1'b0;
    ext_op     = 1'b0;
    alu_ctr    = 3'b000;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;

    if (alu_phase) begin
      case (opcode)
        OP_R: begin
          alu_ctr = funct[2:0];
        end
        OP_ANDI: begin
          alu_ctr = 3'b000;
          alu_src = 1'b1;
          ext_op  = 1'b1;
        end
        OP_ORI: begin
          alu_ctr = 3'b001;
          alu_src = 1'b1;
        end
        OP_BNQ: begin
          alu_ctr = 3'b011;
          ext_op  = 1'b1;
        end
        OP_LW, OP_SW: begin
          alu_ctr = 3'b010;
          alu_src = 1'b1;
          ext_op  = 1'b1;
        end
        default: ;
      endcase
    end

    case (cur)
      S_FETCH: begin
        mem_req  = 1'b1;
        ir_write = mem_ready;
        pc_write = mem_ready;
      end
      S_EXEC: begin
        if (opcode == OP_BNQ) begin
          pc_write = ~zero;
          pc_src   = 1'b1;
        end
      end
      S_MEM: begin
        mem_req = 1'b1;
        i_or_d  = 1'b1;
        mem_we  = (opcode == OP_SW);
      end
      S_WB: begin
        reg_write  = 1'b1;
        reg_dest   = (opcode == OP_R);
        mem_to_reg = (opcode == OP_LW);
      end
      default: ;
    endcase
  end

endmodule
